// File: rtl/queue.sv
// queue: first-word fall-through FIFO with a registered occupancy count.
//
// Parameters
//   W : data width in bits (W >= 1)
//   N : capacity in entries, power of two, N >= 1
//
// Ports
//   clk      in   single clock, rising-edge active
//   rst_n    in   synchronous active-low reset (clears count and pointers)
//   clk_en   in   clock enable; when low no state changes
//   i_valid  in   producer offers data on i
//   i_ready  out  queue can accept an entry (count != N)
//   i        in   data to enqueue
//   o_valid  out  head entry present on o (count != 0)
//   o_ready  in   consumer accepts the head entry
//   o        out  head entry data (don't-care while o_valid is low)
//
// Handshake: a transfer happens on an enabled rising edge when valid and
// ready are both high on the same side; valid never depends on ready.
// i_ready and o_valid are decoded only from the registered count, so a
// push into an empty queue shows up on o one cycle later (no bypass), and
// a pop from a full queue does not free space for a push in the same cycle.
//
// Optional build macro
//   QUEUE_ASSERT_EN : adds simulation-only checks for overflow attempts and
//                     illegal N. Functional behaviour is identical either way.
//
// Storage is intentionally not reset; only count and pointers are.

`default_nettype none

module queue #(
  parameter int W = 32,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [W-1:0] i,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [W-1:0] o
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] count;
  logic [W-1:0]  storage [N];
  logic          push;
  logic          pop;

  assign i_ready = (count != CW'(N));
  assign o_valid = (count != '0);

  assign push = clk_en & i_valid & i_ready;
  assign pop  = clk_en & o_valid & o_ready;

  // Occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

  generate
    if (N == 1) begin : g_single
      // One slot: no pointers, slot 0 is both head and tail.
      always_ff @(posedge clk) begin
        if (push) begin
          storage[0] <= i;
        end
      end

      assign o = storage[0];
    end else begin : g_ring
      localparam int PW = $clog2(N);

      logic [PW-1:0] wr_ptr;
      logic [PW-1:0] rd_ptr;

      // N is a power of two, so the pointers wrap by plain overflow.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
          end
          if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (push) begin
          storage[wr_ptr] <= i;
        end
      end

      assign o = storage[rd_ptr];
    end
  endgenerate

`ifdef QUEUE_ASSERT_EN
  if (N < 1 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("%m: N=%0d must be a power of two and >= 1", N);
  end

  always_ff @(posedge clk) begin
    if (rst_n && clk_en && i_valid && !i_ready) begin
      $error("%m: overflow attempt, i_valid high while i_ready low");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_queue.sv
// tb_queue: drives one shared stimulus stream into two queue instances
// (N=4 and N=1, both W=8). A reference model per instance is an unbounded
// SV queue whose capacity limit is applied from its size. Inputs change
// #1 after each rising edge; the monitor samples on the falling edge,
// checks ready/valid/head against the model, then applies the transfer
// that the coming rising edge will perform.

`timescale 1ns/1ps

module tb_queue;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic         clk_en = 1'b0;
  logic         i_valid = 1'b0;
  logic [W-1:0] i_data = '0;
  logic         o_ready = 1'b0;

  // per-instance outputs
  logic         i_ready4, o_valid4;
  logic [W-1:0] o4;
  logic         i_ready1, o_valid1;
  logic [W-1:0] o1;

  queue #(.W(W), .N(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .i_valid(i_valid),
    .i_ready(i_ready4),
    .i      (i_data),
    .o_valid(o_valid4),
    .o_ready(o_ready),
    .o      (o4)
  );

  queue #(.W(W), .N(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .i_valid(i_valid),
    .i_ready(i_ready1),
    .i      (i_data),
    .o_valid(o_valid1),
    .o_ready(o_ready),
    .o      (o1)
  );

  // scoreboard
  logic [W-1:0] exp_q4[$];
  logic [W-1:0] exp_q1[$];
  int checks = 0;
  int errors = 0;
  int pops4 = 0;
  int pops1 = 0;
  bit armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare outputs with the model, then advance the model
  always @(negedge clk) begin
    bit push4, pop4, push1, pop1;
    if (armed) begin
      check("dut4_i_ready", 32'(i_ready4), 32'(exp_q4.size() < 4));
      check("dut4_o_valid", 32'(o_valid4), 32'(exp_q4.size() != 0));
      if (exp_q4.size() != 0) check("dut4_o", 32'(o4), 32'(exp_q4[0]));
      check("dut1_i_ready", 32'(i_ready1), 32'(exp_q1.size() < 1));
      check("dut1_o_valid", 32'(o_valid1), 32'(exp_q1.size() != 0));
      if (exp_q1.size() != 0) check("dut1_o", 32'(o1), 32'(exp_q1[0]));
    end
    if (!rst_n) begin
      exp_q4.delete();
      exp_q1.delete();
      armed = 1'b1;
    end else if (clk_en) begin
      // capacity decisions use the occupancy before this edge
      pop4  = o_ready && (exp_q4.size() != 0);
      push4 = i_valid && (exp_q4.size() < 4);
      pop1  = o_ready && (exp_q1.size() != 0);
      push1 = i_valid && (exp_q1.size() < 1);
      if (pop4) begin void'(exp_q4.pop_front()); pops4++; end
      if (push4) exp_q4.push_back(i_data);
      if (pop1) begin void'(exp_q1.pop_front()); pops1++; end
      if (push1) exp_q1.push_back(i_data);
    end
  end

  // driver
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic e);
    i_valid = v;
    i_data  = d;
    o_ready = r;
    clk_en  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // first pushes and 1-cycle latency
    cyc(1'b1, 8'h11, 1'b0, 1'b1);
    cyc(1'b1, 8'h22, 1'b0, 1'b1);
    drain(4);

    // fill to capacity, extra offer rejected, then drain in order
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    drain(6);

    // simultaneous push/pop at count 2, then at full
    cyc(1'b1, 8'hB0, 1'b0, 1'b1);
    cyc(1'b1, 8'hB1, 1'b0, 1'b1);
    cyc(1'b1, 8'hB2, 1'b1, 1'b1);
    cyc(1'b1, 8'hB3, 1'b0, 1'b1);
    cyc(1'b1, 8'hB4, 1'b0, 1'b1);
    cyc(1'b1, 8'hB5, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    drain(5);

    // clock enable low freezes everything
    cyc(1'b1, 8'hC0, 1'b0, 1'b1);
    cyc(1'b1, 8'hC1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'hC9, 1'b1, 1'b0);
    drain(4);

    // single-entry behaviour: full pop+push does only the pop
    cyc(1'b1, 8'h05, 1'b0, 1'b1);
    cyc(1'b1, 8'h07, 1'b1, 1'b1);
    cyc(1'b1, 8'h06, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    drain(5);

    // reset mid-operation discards held entries
    cyc(1'b1, 8'hD0, 1'b0, 1'b1);
    cyc(1'b1, 8'hD1, 1'b0, 1'b1);
    cyc(1'b1, 8'hD2, 1'b0, 1'b1);
    rst_n = 1'b0;
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    rst_n = 1'b1;
    cyc(1'b1, 8'hE0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    drain(4);

    // randomized traffic with occasional clock-enable drops and resets
    for (int k = 0; k < 600; k++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      cyc(1'(($urandom_range(0, 3) != 0)), 8'($urandom_range(0, 255)),
          1'(($urandom_range(0, 2) != 0)), 1'(($urandom_range(0, 7) != 0)));
    end
    rst_n = 1'b1;
    drain(6);

    check("dut4_pops_seen", 32'(pops4 > 20), 32'd1);
    check("dut1_pops_seen", 32'(pops1 > 20), 32'd1);
    check("dut4_empty_end", 32'(o_valid4), 32'd0);
    check("dut1_empty_end", 32'(o_valid1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/queue.md
QUEUE -- requirements
Module: queue

Interface
REQ-001 SHALL have parameter W, default 32: data width in bits, W >= 1.
REQ-002 SHALL have parameter N, default 1: capacity in entries, a power of two, N >= 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port clk_en, input, 1 bit: clock enable; when 0, no state changes.
REQ-006 SHALL have port i_valid, input, 1 bit: the producer offers data on i.
REQ-007 SHALL have port i_ready, output, 1 bit: the queue can accept an entry.
REQ-008 SHALL have port i, input, W bits: data to enqueue.
REQ-009 SHALL have port o_valid, output, 1 bit: the head entry is present on o.
REQ-010 SHALL have port o_ready, input, 1 bit: the consumer accepts the head entry.
REQ-011 SHALL have port o, output, W bits: head entry data.

Function
REQ-012 SHALL be a FIFO that delivers entries in the order they were accepted, holding up to N entries.
REQ-013 SHALL keep an occupancy count of $clog2(N+1) bits, covering the range 0..N.
REQ-014 SHALL drive i_ready = (count != N) and o_valid = (count != 0), both decoded directly from registered state.
REQ-015 SHALL define push = clk_en & i_valid & i_ready and pop = clk_en & o_valid & o_ready.
REQ-016 SHALL write i into the tail slot and advance the write pointer on a push.
REQ-017 SHALL advance the read pointer on a pop.
REQ-018 SHALL update the count by +1 on push only, -1 on pop only, and leave it unchanged on both or neither.
REQ-019 SHALL present storage[read pointer] combinationally on o (first-word fall-through).
REQ-020 SHALL make an entry pushed at edge t visible on o with o_valid=1 at edge t+1, giving 1-cycle latency with no bypass when empty.
REQ-021 SHALL use log2(N)-bit pointers that wrap naturally modulo N; when N=1 the pointers are omitted and slot 0 is always used.
REQ-022 SHALL, when full with i_valid=1 and a simultaneous pop, reject the push (i_ready=0), perform the pop, and leave count at N-1.
REQ-023 SHALL, when empty with o_ready=1, perform no pop; o is don't-care while o_valid=0.
REQ-024 SHALL perform push and pop together when 0 < count < N, leaving count unchanged.
REQ-025 SHALL freeze all state, and hold all outputs stable, when clk_en=0.

Reset
REQ-026 SHALL, on a rising edge with rst_n=0, clear count and both pointers to 0, regardless of clk_en.
REQ-027 SHALL drive o_valid=0 and i_ready=1 during and after reset.
REQ-028 SHALL discard any entries held at the time of a reset asserted mid-operation.
REQ-029 SHALL not reset the storage array.

Configuration
REQ-030 SHALL, when QUEUE_ASSERT_EN is defined, include simulation-only checks that issue an $error naming the instance if i_valid=1 and i_ready=0 at an enabled edge (overflow attempt), or if N is not a power of two or is < 1 at elaboration.
REQ-031 SHALL, when QUEUE_ASSERT_EN is undefined, include no checks, with functional behaviour identical.

Verification
REQ-032 SHALL verify reset: with N=4, W=8, after reset o_valid=0 and i_ready=1; with o_ready=0, push 0x11 then 0x22, expecting o_valid=1 and o=0x11 one cycle after the first push.
REQ-033 SHALL verify fill: with N=4 and o_ready=0, push 0xA0..0xA3, expecting i_ready=0 after the 4th push; a 5th offer of 0xA4 is not stored; then drain with o_ready=1, expecting 0xA0,0xA1,0xA2,0xA3 and then o_valid=0.
REQ-034 SHALL verify simultaneous operation: at count=2, push and pop in one cycle, expecting count to stay 2 and the order preserved; when full, push and pop together, expecting count 3 and the pushed value dropped.
REQ-035 SHALL verify clk_en: with clk_en=0, i_valid=1 and o_ready=1 for 3 cycles, expecting outputs unchanged and no entry consumed or added.
REQ-036 SHALL verify N=1: push 0x5 (i_ready becomes 0), then pop and push in the same cycle, expecting only the pop to occur; then push 0x6, expecting o=0x6 next cycle.
REQ-037 SHALL verify mid-operation reset: at count=3, pulse rst_n=0 for one cycle, expecting o_valid=0 and i_ready=1, and expecting the next push to return only the new data.
